// File: rtl/fw_pkg.sv
// Shared definitions for the QSPI flash writer: register offsets, write-enable
// key, lane modes and the byte-engine state encoding.
package fw_pkg;

  localparam logic [2:0] WE_OFF     = 3'd0;
  localparam logic [2:0] SS_OFF     = 3'd1;
  localparam logic [2:0] CFG_OFF    = 3'd2;
  localparam logic [2:0] TXDATA_OFF = 3'd3;
  localparam logic [2:0] RXDATA_OFF = 3'd4;
  localparam logic [2:0] STATUS_OFF = 3'd5;
  localparam logic [2:0] MAGIC_OFF  = 3'd6;

  localparam logic [23:0] WE_KEY = 24'hA5A855;

  typedef enum logic [1:0] {
    LANE_SINGLE = 2'b00,
    LANE_DUAL   = 2'b01,
    LANE_QUAD   = 2'b10
  } lane_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } eng_state_e;

  // The unused lane code 2'b11 behaves as single-lane.
  function automatic lane_e decode_lanes(input logic [1:0] code);
    return (code == 2'b11) ? LANE_SINGLE : lane_e'(code);
  endfunction

endpackage

// File: rtl/fw_sync_fifo.sv
// Small synchronous first-word-fall-through FIFO with flush. A push while full
// is still accepted when a pop happens in the same cycle.
module fw_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

  // Storage array, written on every accepted push.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ahb_qspi_flash_writer.sv
// AHB-Lite slave driving the QSPI flash pins with a hardware byte shifter.
// Optional macro FW_HREADY_STALL_EN: a TXDATA write to a full FIFO stalls the
// bus instead of dropping the byte and flagging overrun.
module ahb_qspi_flash_writer
  import fw_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MAGIC      = 32'hF1A5_0002,
  parameter logic [7:0]  DIV_RST    = 8'd2
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        fm_sck,
  output logic        fm_ce_n,
  input  logic [3:0]  fm_din,
  output logic [3:0]  fm_dout,
  output logic [3:0]  fm_douten
);

  logic       a_valid, a_write;
  logic [2:0] a_addr;
  logic       en, ss, dir_reg, ovr, rx_valid;
  logic [1:0] lanes_reg;
  logic [7:0] div_reg, rx_byte;
  logic       wr_en, rd_en, reg_wr, push, pop, tx_drop, busy;
  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_rdata;

  eng_state_e state, state_next;
  logic [7:0] cnt, cur_div, div_eff, tx_sh, rx_sh, tx_next, rx_next;
  logic [3:0] rise_cnt, total_rises, dout_sel, oen_sel;
  lane_e      cur_lanes;
  logic       cur_dir, sck, phase_end, last_rise;
  logic       unused_bits;

  assign unused_bits = ^{HSIZE, HTRANS[0], HADDR[31:5], HADDR[1:0]};

  // Latch the address phase; it is held while a data phase is being stalled.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_valid <= 1'b0;
      a_write <= 1'b0;
      a_addr  <= '0;
    end else if (HREADY) begin
      a_valid <= HSEL && HTRANS[1];
      a_write <= HWRITE;
      a_addr  <= HADDR[4:2];
    end
  end

  assign wr_en  = a_valid && a_write && HREADYOUT;
  assign rd_en  = a_valid && !a_write && HREADYOUT;
  assign reg_wr = wr_en && en;
  assign push   = reg_wr && (a_addr == TXDATA_OFF);
  assign pop    = en && (state == ST_IDLE) && !fifo_empty;
  assign busy   = (state != ST_IDLE) || !fifo_empty;

`ifdef FW_HREADY_STALL_EN
  assign HREADYOUT = !(a_valid && a_write && en && (a_addr == TXDATA_OFF) && fifo_full && !pop);
  assign tx_drop   = 1'b0;
`else
  assign HREADYOUT = 1'b1;
  assign tx_drop   = push && fifo_full && !pop;
`endif

  fw_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .flush (!en),
    .push  (push),
    .wdata (HWDATA[7:0]),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Software-visible control/status registers; event sets win over clears.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      en        <= 1'b0;
      ss        <= 1'b1;
      div_reg   <= DIV_RST;
      lanes_reg <= 2'b00;
      dir_reg   <= 1'b0;
      ovr       <= 1'b0;
      rx_valid  <= 1'b0;
      rx_byte   <= '0;
    end else begin
      if (wr_en && (a_addr == WE_OFF) && (HWDATA[31:8] == WE_KEY)) en <= HWDATA[0];
      if (reg_wr && (a_addr == SS_OFF)) ss <= HWDATA[0];
      if (reg_wr && (a_addr == CFG_OFF)) begin
        div_reg   <= HWDATA[7:0];
        lanes_reg <= HWDATA[9:8];
        dir_reg   <= HWDATA[10];
      end
      if (reg_wr && (a_addr == STATUS_OFF) && HWDATA[3]) ovr <= 1'b0;
      if (tx_drop || ((state == ST_DONE) && rx_valid)) ovr <= 1'b1;
      if (rd_en && (a_addr == RXDATA_OFF)) rx_valid <= 1'b0;
      if (state == ST_DONE) begin
        rx_byte  <= rx_sh;
        rx_valid <= 1'b1;
      end
    end
  end

  // Read mux driven from the latched address during the data phase.
  always_comb begin
    HRDATA = '0;
    if (rd_en) begin
      case (a_addr)
        WE_OFF:     HRDATA = {31'b0, en};
        SS_OFF:     HRDATA = {31'b0, ss};
        CFG_OFF:    HRDATA = {21'b0, dir_reg, lanes_reg, div_reg};
        RXDATA_OFF: HRDATA = {23'b0, rx_valid, rx_byte};
        STATUS_OFF: HRDATA = {28'b0, ovr, rx_valid, fifo_full, busy};
        MAGIC_OFF:  HRDATA = MAGIC;
        default:    HRDATA = '0;
      endcase
    end
  end

  // Lane-dependent shift, pin mapping and bit-group count for the current byte.
  always_comb begin
    rx_next     = {rx_sh[6:0], fm_din[1]};
    tx_next     = {tx_sh[6:0], 1'b0};
    total_rises = 4'd8;
    dout_sel    = {3'b000, tx_sh[7]};
    oen_sel     = 4'b0001;
    case (cur_lanes)
      LANE_DUAL: begin
        rx_next     = {rx_sh[5:0], fm_din[1:0]};
        tx_next     = {tx_sh[5:0], 2'b00};
        total_rises = 4'd4;
        dout_sel    = {2'b00, tx_sh[7:6]};
        oen_sel     = cur_dir ? 4'b0000 : 4'b0011;
      end
      LANE_QUAD: begin
        rx_next     = {rx_sh[3:0], fm_din[3:0]};
        tx_next     = {tx_sh[3:0], 4'b0000};
        total_rises = 4'd2;
        dout_sel    = tx_sh[7:4];
        oen_sel     = cur_dir ? 4'b0000 : 4'b1111;
      end
      default: ;
    endcase
  end

  assign div_eff   = (cur_div == 8'd0) ? 8'd1 : cur_div;
  assign phase_end = (cnt == div_eff - 8'd1);
  assign last_rise = (rise_cnt == total_rises);

  // Engine state register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Engine next-state logic; disabling the block aborts straight to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (pop) state_next = ST_LOAD;
      ST_LOAD: state_next = ST_LOW;
      ST_LOW:  if (phase_end) state_next = ST_HIGH;
      ST_HIGH: if (phase_end) state_next = last_rise ? ST_DONE : ST_LOW;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (!en) state_next = ST_IDLE;
  end

  // Engine datapath: phase timer, SCK, shift registers and per-byte config.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt       <= '0;
      rise_cnt  <= '0;
      sck       <= 1'b0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      cur_div   <= DIV_RST;
      cur_lanes <= LANE_SINGLE;
      cur_dir   <= 1'b0;
    end else if (!en) begin
      cnt      <= '0;
      rise_cnt <= '0;
      sck      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (pop) tx_sh <= fifo_rdata;
        end
        ST_LOAD: begin
          cur_div   <= div_reg;
          cur_lanes <= decode_lanes(lanes_reg);
          cur_dir   <= dir_reg;
          cnt       <= '0;
          rise_cnt  <= '0;
          rx_sh     <= '0;
        end
        ST_LOW: begin
          if (phase_end) begin
            sck      <= 1'b1;
            cnt      <= '0;
            rise_cnt <= rise_cnt + 4'd1;
            rx_sh    <= rx_next;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_HIGH: begin
          if (phase_end) begin
            sck <= 1'b0;
            cnt <= '0;
            if (!last_rise) tx_sh <= tx_next;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign fm_sck    = sck && en;
  assign fm_ce_n   = en ? ss : 1'b1;
  assign fm_dout   = en ? dout_sel : 4'b0000;
  assign fm_douten = en ? oen_sel : 4'b0000;

endmodule

// File: tb/tb_ahb_qspi_flash_writer.sv
// Self-checking bench for ahb_qspi_flash_writer: AHB register tests, a JEDEC-ID
// flash model, quad output, overrun/stall behaviour and mid-byte reset.
module tb_ahb_qspi_flash_writer;

  localparam int DEPTH = 4;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  wire         HREADY;
  logic [1:0]  HTRANS = 2'b00;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'b010;
  logic [31:0] HADDR = '0;
  logic [31:0] HWDATA = '0;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        fm_sck, fm_ce_n;
  logic [3:0]  fm_din, fm_dout, fm_douten;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stall_cycles = 0;

  logic [7:0]  exp_mosi[$];
  logic [31:0] exp_rx[$];

  ahb_qspi_flash_writer #(.FIFO_DEPTH(DEPTH), .MAGIC(32'hF1A5_0002), .DIV_RST(8'd2)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HADDR(HADDR), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .fm_sck(fm_sck), .fm_ce_n(fm_ce_n),
    .fm_din(fm_din), .fm_dout(fm_dout), .fm_douten(fm_douten)
  );

  assign HREADY = HREADYOUT;

  // Clock and free-running cycle counter.
  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc++;

  // Overall time limit.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Flash model: answers JEDEC-ID (0x9F) on IO1 with BF 26 58, mode 0.
  logic        miso = 1'b0;
  logic        f_active = 1'b0;
  logic [7:0]  f_cmd = '0;
  int          f_bits = 0;
  logic [23:0] f_resp = '0;

  assign fm_din = {2'b00, miso, 1'b0};

  always @(posedge fm_sck) begin
    if (!fm_ce_n && !f_active) begin
      f_cmd = {f_cmd[6:0], fm_dout[0]};
      f_bits++;
      if (f_bits == 8 && f_cmd == 8'h9F) begin
        f_active = 1'b1;
        f_resp   = 24'hBF2658;
      end
    end
  end

  always @(negedge fm_sck) begin
    if (f_active) begin
      miso   = f_resp[23];
      f_resp = f_resp << 1;
    end
  end

  always @(posedge fm_ce_n) begin
    f_active = 1'b0;
    f_bits   = 0;
    miso     = 1'b0;
  end

  // Pin monitor: assembles shifted-out bytes and checks them against the queue.
  int         mon_lanes = 1;
  int         mon_bits = 0;
  int         mon_rises = 0;
  int         last_rise_cyc = 0;
  int         sck_period = 0;
  logic [7:0] mon_byte = '0;

  always @(posedge fm_sck) begin
    mon_rises++;
    if (mon_bits > 0) sck_period = cyc - last_rise_cyc;
    last_rise_cyc = cyc;
    case (mon_lanes)
      4:       mon_byte = {mon_byte[3:0], fm_dout[3:0]};
      2:       mon_byte = {mon_byte[5:0], fm_dout[1:0]};
      default: mon_byte = {mon_byte[6:0], fm_dout[0]};
    endcase
    mon_bits += mon_lanes;
    if (mon_bits >= 8) begin
      mon_bits = 0;
      if (exp_mosi.size() == 0) check_output("mosi_unexpected", exp_mosi.size(), 1);
      else check_output("mosi", mon_byte, exp_mosi.pop_front());
    end
  end

  always @(posedge fm_ce_n) mon_bits = 0;

  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
    int waits;
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
    waits = 0;
    while (!HREADYOUT && waits < 2000) begin
      @(negedge HCLK);
      waits++;
    end
    if (waits >= 2000) check_output("hready_timeout", waits, 0);
    stall_cycles += waits;
    @(posedge HCLK);
  endtask

  task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00;
    data = HRDATA;
  endtask

  task automatic wait_idle();
    logic [31:0] st;
    int polls;
    polls = 0;
    st = 32'h1;
    while (st[0] && polls < 2000) begin
      ahb_read(32'h14, st);
      polls++;
    end
    if (st[0]) check_output("idle_timeout", st, 0);
  endtask

  task automatic wait_sck_high();
    int n;
    n = 0;
    while (!fm_sck && n < 500) begin
      @(negedge HCLK);
      n++;
    end
    if (!fm_sck) check_output("sck_timeout", {31'b0, fm_sck}, 1);
  endtask

  task automatic read_rx();
    logic [31:0] d;
    ahb_read(32'h10, d);
    if (exp_rx.size() == 0) check_output("rx_unexpected", exp_rx.size(), 1);
    else check_output("rxdata", d, exp_rx.pop_front());
  endtask

  task automatic apply_stimulus(input logic [7:0] tx, input logic [31:0] rx_exp);
    exp_mosi.push_back(tx);
    exp_rx.push_back(rx_exp);
    ahb_write(32'h0C, {24'h0, tx});
  endtask

  task automatic toggle_ss();
    ahb_write(32'h04, 32'h1);
    ahb_write(32'h04, 32'h0);
  endtask

  logic [31:0] rd;
  logic [7:0]  jedec_tx [4] = '{8'h9F, 8'h00, 8'h00, 8'h00};
  logic [31:0] jedec_rx [4] = '{32'h100, 32'h1BF, 32'h126, 32'h158};

  initial begin
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    check_output("rst_sck", {31'b0, fm_sck}, 0);
    check_output("rst_ce_n", {31'b0, fm_ce_n}, 1);

    // Basic register access and write-enable key.
    ahb_read(32'h18, rd);
    check_output("magic", rd, 32'hF1A5_0002);
    ahb_read(32'h00, rd);
    check_output("we_reset", rd, 0);
    ahb_write(32'h00, 32'h1234_5601);
    ahb_read(32'h00, rd);
    check_output("we_badkey", rd, 0);
    ahb_write(32'h00, 32'hA5A8_5501);
    ahb_read(32'h00, rd);
    check_output("we_enable", rd, 1);

    // JEDEC ID in single-lane mode, div 2.
    ahb_write(32'h04, 32'h0);
    ahb_write(32'h08, 32'h002);
    mon_lanes = 1;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(jedec_tx[i], jedec_rx[i]);
      wait_idle();
      read_rx();
    end
    check_output("sck_period", sck_period, 4);
    ahb_read(32'h10, rd);
    check_output("rx_cleared", rd, 32'h058);

    // Quad write of 0xA5.
    toggle_ss();
    ahb_write(32'h08, 32'h202);
    mon_lanes = 4;
    mon_rises = 0;
    apply_stimulus(8'hA5, 32'h100);
    wait_sck_high();
    check_output("quad_douten", {28'b0, fm_douten}, 32'hF);
    wait_idle();
    check_output("quad_rises", mon_rises, 2);
    read_rx();

    // Two bytes without an RXDATA read: overrun, second byte retained.
    toggle_ss();
    ahb_write(32'h08, 32'h002);
    mon_lanes = 1;
    exp_mosi.push_back(8'h9F);
    exp_mosi.push_back(8'h00);
    exp_rx.push_back(32'h1BF);
    ahb_write(32'h0C, 32'h9F);
    ahb_write(32'h0C, 32'h00);
    wait_idle();
    ahb_read(32'h14, rd);
    check_output("status_ovr", rd, 32'hC);
    read_rx();
    ahb_write(32'h14, 32'h8);
    ahb_read(32'h14, rd);
    check_output("ovr_w1c", rd, 0);

    // Back-to-back pushes beyond FIFO capacity, div 8.
    toggle_ss();
    ahb_write(32'h08, 32'h008);
    stall_cycles = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
`ifdef FW_HREADY_STALL_EN
      exp_mosi.push_back(8'h11 + 8'(i));
`else
      if (i < DEPTH + 1) exp_mosi.push_back(8'h11 + 8'(i));
`endif
      ahb_write(32'h0C, 32'h11 + 32'(i));
    end
    ahb_read(32'h14, rd);
`ifdef FW_HREADY_STALL_EN
    check_output("tx_ovr", {31'b0, rd[3]}, 0);
    check_output("stalled", {31'b0, stall_cycles > 0}, 1);
`else
    check_output("tx_ovr", {31'b0, rd[3]}, 1);
`endif
    wait_idle();
    check_output("all_shifted", exp_mosi.size(), 0);
    ahb_write(32'h14, 32'h8);
    ahb_read(32'h10, rd);

    // Asynchronous reset while SCK is high.
    toggle_ss();
    apply_stimulus(8'h5A, 32'h0);
    wait_sck_high();
    HRESETn = 1'b0;
    #1;
    check_output("arst_sck", {31'b0, fm_sck}, 0);
    check_output("arst_ce_n", {31'b0, fm_ce_n}, 1);
    check_output("arst_douten", {28'b0, fm_douten}, 0);
    exp_mosi.delete();
    exp_rx.delete();
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    ahb_read(32'h14, rd);
    check_output("arst_status", rd, 0);
    ahb_read(32'h00, rd);
    check_output("arst_we", rd, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
